full_st0_out_serializer: RTL and testbench
==========================================

Name: full_st0_out_serializer

Overview:
- Sits directly upstream of the stage-1 control/data FIFO and drives its stage_1_data / stage_1_data_vld / stage_1_data_fst / stage_1_data_rdy interface.
- Accepts a full parallel output vector from the stage-0 accumulator array (one float_24_8 word per lane) through a valid/ready handshake.
- Buffers up to two vectors (ping-pong) and serializes each one, lane 0 first, into a one-word-per-cycle valid/ready stream.
- Marks the first word of every vector with a fst flag.

Parameters:
- LANES, 16, number of lanes per input vector; bounds the programmable length (load_length is 4 bits).
- WIDTH, 32, bits per lane word (float_24_8, sign in bit WIDTH-1).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- load_length  input  4  lanes per vector minus 1; sampled per vector at acceptance.
- vec_in  input  LANES*WIDTH  parallel vector; lane k occupies bits [k*WIDTH +: WIDTH].
- vec_in_vld  input  1  vec_in valid.
- vec_in_rdy  output  1  a buffer slot is free.
- stage_1_data  output  WIDTH  serialized lane word.
- stage_1_data_vld  output  1  stage_1_data valid.
- stage_1_data_fst  output  1  current word is lane 0 of a vector.
- stage_1_data_rdy  input  1  downstream ready.
- vec_done  output  1  one-cycle pulse on the handshake of the last lane of a vector.
- occupancy  output  2  number of filled slots (0..2).

Behaviour:
- Reset values: vec_in_rdy=1 (combinational, occupancy=0), stage_1_data=0, stage_1_data_vld=0, stage_1_data_fst=0, vec_done=0, occupancy=0, wr_ptr=rd_ptr=0, lane_cnt=0, FSM=IDLE.
- Reset asserted mid-vector: all buffered and in-flight data is discarded; stage_1_data_vld drops asynchronously.
- Input handshake:
  - vec_in_rdy = (occupancy != 2).
  - Accept when vec_in_vld & vec_in_rdy: write vec_in into slot[wr_ptr], store len[wr_ptr] = min(load_length, LANES-1), toggle wr_ptr.
- Occupancy:
  - Increments on accept and decrements on release.
  - Simultaneous accept and release leaves it unchanged.
  - It never exceeds 2 and never underflows.
- Output register advance: the output register loads when (~stage_1_data_vld | stage_1_data_rdy).
  - If a slot is filled (occupancy>0), load stage_1_data = slot[rd_ptr] lane lane_cnt, stage_1_data_vld=1, stage_1_data_fst = (lane_cnt==0).
  - Otherwise clear stage_1_data_vld and stage_1_data_fst on advance; stage_1_data holds its value.
- Output hold: while stage_1_data_vld & ~stage_1_data_rdy, stage_1_data, stage_1_data_fst and stage_1_data_vld hold stable.
- FSM:
  - IDLE→STREAM when occupancy>0 and the output register advances; lane 0 is loaded.
  - In STREAM, each advance that loads lane_cnt==len[rd_ptr] releases the slot: toggle rd_ptr, reset lane_cnt to 0.
  - Otherwise each advance increments lane_cnt by 1.
  - STREAM→IDLE when a slot is released and the other slot is empty.
  - If the other slot is full, continue with its lane 0 on the next advance: no bubble between vectors.
- Release timing: a slot is released when its last lane is loaded into the output register, not when that lane is handshaked, so the slot may be refilled while the last word waits.
- vec_done: asserted for the cycle after the handshake (stage_1_data_vld & stage_1_data_rdy) of the word loaded as the last lane; it is registered.
- Latency: a vector accepted at edge E produces stage_1_data_vld=1 with lane 0 after edge E+1. With rdy held high, throughput is 1 word/cycle.
- Single-lane vectors (load_length=0): every word has fst=1, and each vector releases after one word.
- load_length > LANES-1: clamped to LANES-1.

Optional Feature:
- Macro FULL_ST0_OUT_SER_RELU_EN.
- When defined: any lane word whose bit WIDTH-1 is 1 is replaced by all zeros as it is loaded into stage_1_data (ReLU on the stage-0 output). fst, vld and timing are unchanged.
- When undefined: words pass through unmodified.

Test Plan:
- Reset, then one vector (load_length=3, lanes 0..3 = 0x11,0x22,0x33,0x44), rdy=1 -> vld after edge E+1; data sequence 0x11,0x22,0x33,0x44 on consecutive cycles; fst=1 only on 0x11; vec_done pulses once; occupancy returns to 0.
- Three back-to-back vectors (load_length=15), rdy=1 -> vec_in_rdy drops when occupancy=2; 48 words are emitted with no idle cycle between vectors; fst appears on words 0, 16, 32.
- rdy toggled 1,0,0,1 pattern during a vector (load_length=7) -> data is held while rdy=0; all 8 words are emitted exactly once and in order.
- load_length=0 with 4 vectors -> 4 words, each with fst=1, and 4 vec_done pulses.
- Reset asserted mid-vector (lane 5 of 16) -> vld=0 immediately; occupancy=0; the next vector starts at lane 0 with fst=1.
- With FULL_ST0_OUT_SER_RELU_EN: lane values 0x80000001 and 0x3F800000 -> output 0x00000000 and 0x3F800000. Without the macro: both pass unchanged.

Source files
------------

// File: rtl/full_st0_out_serializer_if.sv
// Handshake bundle between the stage-0 accumulator array, the serializer and the
// stage-1 control/data FIFO. The slave modport is the serializer's view.
interface full_st0_out_serializer_if #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
);
  logic [3:0]             load_length;
  logic [LANES*WIDTH-1:0] vec_in;
  logic                   vec_in_vld;
  logic                   vec_in_rdy;
  logic [WIDTH-1:0]       stage_1_data;
  logic                   stage_1_data_vld;
  logic                   stage_1_data_fst;
  logic                   stage_1_data_rdy;
  logic                   vec_done;
  logic [1:0]             occupancy;

  modport slave (
    input  load_length, vec_in, vec_in_vld, stage_1_data_rdy,
    output vec_in_rdy, stage_1_data, stage_1_data_vld, stage_1_data_fst,
           vec_done, occupancy
  );

  modport master (
    output load_length, vec_in, vec_in_vld, stage_1_data_rdy,
    input  vec_in_rdy, stage_1_data, stage_1_data_vld, stage_1_data_fst,
           vec_done, occupancy
  );
endinterface

// File: rtl/full_st0_out_serializer.sv
// Ping-pong buffers stage-0 output vectors and streams them lane 0 first into stage 1.
// Optional FULL_ST0_OUT_SER_RELU_EN zeroes negative lane words as they are loaded.
module full_st0_out_serializer #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  full_st0_out_serializer_if.slave     bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [3:0] MAX_LEN = 4'(LANES - 1);

  logic [WIDTH-1:0] slot [2][LANES];
  logic [3:0]       len  [2];
  logic             wr_ptr, rd_ptr;
  logic [3:0]       lane_cnt, lane_cnt_next;
  logic [1:0]       occ_q, occ_next;
  logic [WIDTH-1:0] data_q;
  logic             vld_q, fst_q, last_q, done_q;
  state_t           state, state_next;

  logic             in_rdy, accept, advance, load, release_slot;
  logic [3:0]       len_in;
  logic [WIDTH-1:0] word_sel, word_out;

  assign in_rdy                = (occ_q != 2'd2);
  assign bus.vec_in_rdy        = in_rdy;
  assign bus.stage_1_data      = data_q;
  assign bus.stage_1_data_vld  = vld_q;
  assign bus.stage_1_data_fst  = fst_q;
  assign bus.vec_done          = done_q;
  assign bus.occupancy         = occ_q;

  always_comb begin
    accept        = bus.vec_in_vld && in_rdy;
    advance       = !vld_q || bus.stage_1_data_rdy;
    load          = advance && (occ_q != 2'd0);
    // The slot frees as soon as its last lane enters the output register.
    release_slot  = load && (lane_cnt == len[rd_ptr]);
    len_in        = (bus.load_length > MAX_LEN) ? MAX_LEN : bus.load_length;

    occ_next = occ_q;
    if (accept && !release_slot)
      occ_next = occ_q + 2'd1;
    else if (!accept && release_slot)
      occ_next = occ_q - 2'd1;

    lane_cnt_next = lane_cnt;
    if (load)
      lane_cnt_next = release_slot ? '0 : lane_cnt + 4'd1;

    state_next = state;
    unique case (state)
      IDLE:   if (load) state_next = (release_slot && occ_next == 2'd0) ? IDLE : STREAM;
      STREAM: if (release_slot && occ_next == 2'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    word_sel = slot[rd_ptr][lane_cnt];
`ifdef FULL_ST0_OUT_SER_RELU_EN
    word_out = word_sel[WIDTH-1] ? '0 : word_sel;
`else
    word_out = word_sel;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      lane_cnt <= '0;
      occ_q    <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      fst_q    <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      len[0]   <= '0;
      len[1]   <= '0;
      for (int unsigned s = 0; s < 2; s++)
        for (int unsigned k = 0; k < LANES; k++)
          slot[s][k] <= '0;
    end else begin
      state    <= state_next;
      lane_cnt <= lane_cnt_next;
      occ_q    <= occ_next;
      done_q   <= vld_q && bus.stage_1_data_rdy && last_q;

      if (accept) begin
        for (int unsigned k = 0; k < LANES; k++)
          slot[wr_ptr][k] <= bus.vec_in[k*WIDTH +: WIDTH];
        len[wr_ptr] <= len_in;
        wr_ptr      <= !wr_ptr;
      end

      if (release_slot)
        rd_ptr <= !rd_ptr;

      if (advance) begin
        if (occ_q != 2'd0) begin
          data_q <= word_out;
          vld_q  <= 1'b1;
          fst_q  <= (lane_cnt == 4'd0);
          last_q <= release_slot;
        end else begin
          vld_q  <= 1'b0;
          fst_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_full_st0_out_serializer.sv
// Directed and randomized bench for full_st0_out_serializer against a word-queue reference.
module tb_full_st0_out_serializer;
  localparam int LANES = 16;
  localparam int WIDTH = 32;
`ifdef FULL_ST0_OUT_SER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  full_st0_out_serializer_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  full_st0_out_serializer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    bit          fst;
    bit          last;
  } word_t;

  word_t       q[$];
  int          hs_cyc[$];
  int          hs_cnt = 0, done_cnt = 0, cyc = 0;
  bit          exp_done = 0, saw_full = 0, hold_pend = 0;
  logic [31:0] hold_data;
  logic        hold_fst;
  word_t       w;
  int          mode = 0, pi = 0;
  bit   [3:0]  pat = 4'b1001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] x);
    return (RELU && x[31]) ? 32'h0 : x;
  endfunction

  function automatic logic [LANES*WIDTH-1:0] rand_vec();
    logic [LANES*WIDTH-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = $urandom();
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Reference: every accepted vector becomes a queue of expected words.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_done  = 0;
      hold_pend = 0;
    end else begin
      check("vec_done", bus.vec_done, exp_done);
      if (bus.vec_done) done_cnt++;
      exp_done = 0;
      if (hold_pend) begin
        check("hold_vld", bus.stage_1_data_vld, 1);
        check("hold_data", bus.stage_1_data, hold_data);
        check("hold_fst", bus.stage_1_data_fst, hold_fst);
        hold_pend = 0;
      end
      check("in_rdy", bus.vec_in_rdy, bus.occupancy != 2'd2);
      check("occ_range", bus.occupancy == 2'd3, 0);
      if (bus.occupancy == 2'd2) saw_full = 1;
      if (bus.stage_1_data_vld && bus.stage_1_data_rdy) begin
        if (q.size() == 0) check("extra_word", 1, 0);
        else begin
          w = q.pop_front();
          check("data", bus.stage_1_data, w.data);
          check("fst", bus.stage_1_data_fst, w.fst);
          exp_done = w.last;
        end
        hs_cnt++;
        hs_cyc.push_back(cyc);
      end else if (bus.stage_1_data_vld) begin
        hold_pend = 1;
        hold_data = bus.stage_1_data;
        hold_fst  = bus.stage_1_data_fst;
      end
      if (bus.vec_in_vld && bus.vec_in_rdy) begin
        int n;
        n = (int'(bus.load_length) > LANES - 1) ? LANES - 1 : int'(bus.load_length);
        for (int k = 0; k <= n; k++) begin
          word_t nw;
          nw.data = ref_word(bus.vec_in[k*WIDTH +: WIDTH]);
          nw.fst  = (k == 0);
          nw.last = (k == n);
          q.push_back(nw);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (mode)
      0: bus.stage_1_data_rdy = 1'b1;
      1: begin bus.stage_1_data_rdy = pat[pi % 4]; pi++; end
      default: bus.stage_1_data_rdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_vec(input logic [3:0] ll, input logic [LANES*WIDTH-1:0] v);
    bus.load_length = ll;
    bus.vec_in      = v;
    bus.vec_in_vld  = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (bus.vec_in_rdy) begin
        step();
        bus.vec_in_vld = 1'b0;
        return;
      end
      step();
    end
    check("accept_timeout", 0, 1);
    bus.vec_in_vld = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      if (q.size() == 0 && !bus.stage_1_data_vld && bus.occupancy == 2'd0) break;
      step();
    end
    step();
    step();
    check("drain_q", q.size(), 0);
    check("drain_occ", bus.occupancy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*WIDTH-1:0] v;
    int h0, d0;
    reset = 1'b1;
    bus.vec_in_vld = 1'b0;
    bus.vec_in = '0;
    bus.load_length = '0;
    bus.stage_1_data_rdy = 1'b1;
    repeat (3) step();
    check("rst_vld", bus.stage_1_data_vld, 0);
    check("rst_fst", bus.stage_1_data_fst, 0);
    check("rst_data", bus.stage_1_data, 0);
    check("rst_done", bus.vec_done, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_in_rdy", bus.vec_in_rdy, 1);
    reset = 1'b0;
    step();

    // Single 4-lane vector, latency and vec_done
    v = '0;
    v[0*WIDTH +: WIDTH] = 32'h11;
    v[1*WIDTH +: WIDTH] = 32'h22;
    v[2*WIDTH +: WIDTH] = 32'h33;
    v[3*WIDTH +: WIDTH] = 32'h44;
    d0 = done_cnt;
    send_vec(4'd3, v);
    check("t1_vld_at_E", bus.stage_1_data_vld, 0);
    step();
    check("t1_vld_E1", bus.stage_1_data_vld, 1);
    check("t1_data_E1", bus.stage_1_data, 32'h11);
    check("t1_fst_E1", bus.stage_1_data_fst, 1);
    drain();
    check("t1_done_cnt", done_cnt - d0, 1);

    // Three back-to-back full vectors
    h0 = hs_cnt;
    saw_full = 0;
    repeat (3) send_vec(4'd15, rand_vec());
    drain();
    check("t2_words", hs_cnt - h0, 48);
    check("t2_no_bubble", hs_cyc[h0+47] - hs_cyc[h0], 47);
    check("t2_saw_full", saw_full, 1);

    // Backpressure pattern 1,0,0,1
    mode = 1;
    pi = 0;
    h0 = hs_cnt;
    send_vec(4'd7, rand_vec());
    drain();
    mode = 0;
    check("t3_words", hs_cnt - h0, 8);

    // Single-lane vectors
    h0 = hs_cnt;
    d0 = done_cnt;
    repeat (4) send_vec(4'd0, rand_vec());
    drain();
    check("t4_words", hs_cnt - h0, 4);
    check("t4_done_cnt", done_cnt - d0, 4);

    // Reset while lane 5 of 16 is in the output register
    h0 = hs_cnt;
    send_vec(4'd15, rand_vec());
    for (int t = 0; t < 100 && hs_cnt < h0 + 5; t++) step();
    check("t5_reached_lane5", hs_cnt - h0, 5);
    #2 reset = 1'b1;
    #1;
    check("t5_vld_async", bus.stage_1_data_vld, 0);
    check("t5_occ", bus.occupancy, 0);
    check("t5_in_rdy", bus.vec_in_rdy, 1);
    step();
    reset = 1'b0;
    step();
    v = rand_vec();
    send_vec(4'd3, v);
    step();
    check("t5_restart_vld", bus.stage_1_data_vld, 1);
    check("t5_restart_data", bus.stage_1_data, ref_word(v[0 +: WIDTH]));
    check("t5_restart_fst", bus.stage_1_data_fst, 1);
    drain();

    // Sign-bit handling
    v = '0;
    v[0*WIDTH +: WIDTH] = 32'h8000_0001;
    v[1*WIDTH +: WIDTH] = 32'h3F80_0000;
    send_vec(4'd1, v);
    step();
    check("t6_neg_word", bus.stage_1_data, RELU ? 32'h0 : 32'h8000_0001);
    step();
    check("t6_pos_word", bus.stage_1_data, 32'h3F80_0000);
    drain();

    // Randomized traffic with random backpressure
    mode = 2;
    for (int i = 0; i < 30; i++) begin
      send_vec(4'($urandom_range(0, 15)), rand_vec());
      repeat ($urandom_range(0, 3)) step();
    end
    drain();
    mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
